stdcell_sweep: RTL and testbench

Parametrised, synthesizable exhaustive-sweep checker for combinational standard cells with up to 6 inputs.
- Drives every input combination onto a cell under test, waits a programmable settle time, and compares the cell outputs against a golden truth table supplied as a flat vector.
- Counts mismatches and records the first failing index.
- Sits in the stdcell verification harness and replaces per-cell hand-written check sequences with one reusable sequential block, e.g. sweeping INVX1 or NAND2X1 under simulation or on an FPGA harness.

---
 rtl/stdcell_sweep_pkg.sv | 15 +
 rtl/stdcell_sweep_satcnt.sv | 35 +++
 rtl/stdcell_sweep.sv | 131 +++++++++++++
 tb/tb_stdcell_sweep.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stdcell_sweep_pkg.sv
// Shared types and limits for the exhaustive standard-cell sweep checker.
package stdcell_sweep_pkg;

  localparam int unsigned MAX_NINPUTS  = 6;
  localparam int unsigned MAX_NOUTPUTS = 4;
  localparam int unsigned MAX_SETTLE   = 15;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } sweep_state_e;

endpackage

// File: rtl/stdcell_sweep_satcnt.sv
// Saturating up-counter with synchronous clear; holds the mismatch count.
module stdcell_sweep_satcnt
  import stdcell_sweep_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/stdcell_sweep.sv
// Drives every input combination onto a combinational cell, waits SETTLE cycles,
// and compares the cell outputs against a flat golden truth table.
module stdcell_sweep
  import stdcell_sweep_pkg::*;
#(
  parameter int unsigned NINPUTS  = 1,
  parameter int unsigned NOUTPUTS = 1,
  parameter int unsigned SETTLE   = 1,
  parameter int unsigned ERRW     = 8,
  localparam int unsigned NVEC    = 1 << NINPUTS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NOUTPUTS*NVEC-1:0] golden,
  output logic [NINPUTS-1:0]       stim,
  input  logic [NOUTPUTS-1:0]      dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERRW-1:0]          err_count,
  output logic [NINPUTS-1:0]       first_err
);

  if (NINPUTS < 1 || NINPUTS > MAX_NINPUTS) begin : g_bad_ninputs
    $error("stdcell_sweep: NINPUTS out of range 1..6");
  end
  if (NOUTPUTS < 1 || NOUTPUTS > MAX_NOUTPUTS) begin : g_bad_noutputs
    $error("stdcell_sweep: NOUTPUTS out of range 1..4");
  end
  if (SETTLE < 1 || SETTLE > MAX_SETTLE) begin : g_bad_settle
    $error("stdcell_sweep: SETTLE out of range 1..15");
  end
  if (ERRW < 1) begin : g_bad_errw
    $error("stdcell_sweep: ERRW must be at least 1");
  end

  localparam logic [3:0]         CntInit  = 4'(SETTLE - 1);
  localparam logic [NINPUTS-1:0] LastStim = '1;

  sweep_state_e         state_q;
  logic [NINPUTS-1:0]   stim_q, first_err_q;
  logic [3:0]           cnt_q;
  logic                 busy_q, done_q, pass_q;
  logic [NOUTPUTS-1:0]  expected;
  logic                 mismatch;
  logic                 err_clear, err_inc;

  assign expected = golden[stim_q*NOUTPUTS +: NOUTPUTS];
  // Case inequality: X/Z on the cell output counts as a mismatch in 4-state simulation.
  assign mismatch = (dut_out !== expected);

  assign err_clear = (state_q == StIdle) || ((state_q == StDone) && start);
  assign err_inc   = (state_q == StCheck) && mismatch;

  stdcell_sweep_satcnt #(
    .W(ERRW)
  ) u_satcnt (
    .clk  (clk),
    .reset(reset),
    .clear(err_clear),
    .inc  (err_inc),
    .count(err_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      stim_q      <= '0;
      first_err_q <= '0;
      cnt_q       <= CntInit;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          stim_q      <= '0;
          first_err_q <= '0;
          cnt_q       <= CntInit;
          if (start) begin
            state_q <= StSettle;
            busy_q  <= 1'b1;
          end
        end
        StSettle: begin
          if (cnt_q == 4'd0) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StCheck: begin
          if (mismatch && (err_count == '0)) begin
            first_err_q <= stim_q;
          end
          if (stim_q == LastStim) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // err_count has not yet absorbed this cycle's compare.
            pass_q  <= (err_count == '0) && !mismatch;
          end else begin
            stim_q  <= stim_q + 1'b1;
            cnt_q   <= CntInit;
            state_q <= StSettle;
          end
        end
        StDone: begin
          if (start) begin
            state_q     <= StSettle;
            stim_q      <= '0;
            first_err_q <= '0;
            cnt_q       <= CntInit;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stim      = stim_q;
  assign first_err = first_err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_stdcell_sweep.sv
// Directed bench: INV, NAND2 (with AND fault model), slow-settling cell and saturation.
module tb_stdcell_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   total = 0;
  int   bad   = 0;

  // INVX1: NINPUTS=1, SETTLE=1
  logic       inv_start, inv_force_x, inv_out;
  logic [0:0] inv_stim, inv_first;
  logic       inv_busy, inv_done, inv_pass;
  logic [7:0] inv_err;
  always_comb inv_out = (inv_force_x && (inv_stim == 1'b0)) ? 1'bx : ~inv_stim[0];

  stdcell_sweep #(
    .NINPUTS(1), .NOUTPUTS(1), .SETTLE(1), .ERRW(8)
  ) u_inv (
    .clk(clk), .reset(reset), .start(inv_start), .golden(2'b01), .stim(inv_stim),
    .dut_out(inv_out), .busy(inv_busy), .done(inv_done), .pass(inv_pass),
    .err_count(inv_err), .first_err(inv_first)
  );

  // NAND2X1 with selectable AND fault model
  logic       nand_start, nand_use_and, nand_out;
  logic [3:0] nand_golden;
  logic [1:0] nand_stim, nand_first;
  logic       nand_busy, nand_done, nand_pass;
  logic [7:0] nand_err;
  always_comb nand_out = nand_use_and ? (&nand_stim) : ~(&nand_stim);

  stdcell_sweep #(
    .NINPUTS(2), .NOUTPUTS(1), .SETTLE(1), .ERRW(8)
  ) u_nand (
    .clk(clk), .reset(reset), .start(nand_start), .golden(nand_golden), .stim(nand_stim),
    .dut_out(nand_out), .busy(nand_busy), .done(nand_done), .pass(nand_pass),
    .err_count(nand_err), .first_err(nand_first)
  );

  // NAND2 whose output lags stim by one cycle, SETTLE=3
  logic       slow_start, slow_out;
  logic [1:0] slow_stim, slow_first;
  logic       slow_busy, slow_done, slow_pass;
  logic [7:0] slow_err;
  always @(posedge clk) slow_out <= ~(&slow_stim);

  stdcell_sweep #(
    .NINPUTS(2), .NOUTPUTS(1), .SETTLE(3), .ERRW(8)
  ) u_slow (
    .clk(clk), .reset(reset), .start(slow_start), .golden(4'b0111), .stim(slow_stim),
    .dut_out(slow_out), .busy(slow_busy), .done(slow_done), .pass(slow_pass),
    .err_count(slow_err), .first_err(slow_first)
  );

  // Saturation: ERRW=2, mismatches on vectors 2..7
  logic       sat_start, sat_out;
  logic [2:0] sat_stim, sat_first;
  logic       sat_busy, sat_done, sat_pass;
  logic [1:0] sat_err;
  always_comb sat_out = (sat_stim >= 3'd2);

  stdcell_sweep #(
    .NINPUTS(3), .NOUTPUTS(1), .SETTLE(1), .ERRW(2)
  ) u_sat (
    .clk(clk), .reset(reset), .start(sat_start), .golden(8'h00), .stim(sat_stim),
    .dut_out(sat_out), .busy(sat_busy), .done(sat_done), .pass(sat_pass),
    .err_count(sat_err), .first_err(sat_first)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0: inv_start = v;
      1: nand_start = v;
      2: slow_start = v;
      default: sat_start = v;
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return inv_done;
      1: return nand_done;
      2: return slow_done;
      default: return sat_done;
    endcase
  endfunction

  // Pulses start, returns the cycle (edge 0 = start sample) in which done is seen.
  task automatic sweep(input int which, output int cyc);
    set_start(which, 1'b1);
    tick();
    set_start(which, 1'b0);
    cyc = 1;
    while (!get_done(which) && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  int cyc;

  initial begin
    reset = 1'b1;
    inv_start = 1'b0; inv_force_x = 1'b0;
    nand_start = 1'b0; nand_use_and = 1'b0; nand_golden = 4'b0111;
    slow_start = 1'b0; sat_start = 1'b0;
    tick();
    tick();
    check("rst_stim", 32'(inv_stim), 32'd0);
    check("rst_busy", 32'(inv_busy), 32'd0);
    check("rst_done", 32'(nand_done), 32'd0);
    check("rst_pass", 32'(nand_pass), 32'd0);
    check("rst_err", 32'(sat_err), 32'd0);
    reset = 1'b0;
    tick();

    // INVX1 good sweep with stim sequencing
    inv_start = 1'b1;
    tick();
    inv_start = 1'b0;
    cyc = 1;
    check("inv_busy_c1", 32'(inv_busy), 32'd1);
    check("inv_stim_c1", 32'(inv_stim), 32'd0);
    while (!inv_done && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 2) check("inv_stim_c2", 32'(inv_stim), 32'd0);
      if (cyc == 3) check("inv_stim_c3", 32'(inv_stim), 32'd1);
    end
    check("inv_done_cyc", 32'(cyc), 32'd5);
    check("inv_pass", 32'(inv_pass), 32'd1);
    check("inv_err", 32'(inv_err), 32'd0);
    check("inv_busy_done", 32'(inv_busy), 32'd0);

    // X on vector 0 is a mismatch
    inv_force_x = 1'b1;
    sweep(0, cyc);
    inv_force_x = 1'b0;
    check("invx_done_cyc", 32'(cyc), 32'd5);
    check("invx_err", 32'(inv_err), 32'd1);
    check("invx_first", 32'(inv_first), 32'd0);
    check("invx_pass", 32'(inv_pass), 32'd0);

    // NAND golden, AND behaviour: every vector fails
    nand_golden = 4'b0111;
    nand_use_and = 1'b1;
    sweep(1, cyc);
    check("and_done_cyc", 32'(cyc), 32'd9);
    check("and_err", 32'(nand_err), 32'd4);
    check("and_first", 32'(nand_first), 32'd0);
    check("and_pass", 32'(nand_pass), 32'd0);

    // Corrupted golden entry 2
    nand_use_and = 1'b0;
    nand_golden = 4'b0011;
    sweep(1, cyc);
    check("badg_err", 32'(nand_err), 32'd1);
    check("badg_first", 32'(nand_first), 32'd2);
    check("badg_pass", 32'(nand_pass), 32'd0);
    check("badg_done", 32'(nand_done), 32'd1);

    // Slow cell, SETTLE=3
    sweep(2, cyc);
    check("slow_done_cyc", 32'(cyc), 32'd17);
    check("slow_pass", 32'(slow_pass), 32'd1);
    check("slow_err", 32'(slow_err), 32'd0);

    // Saturation at 3 with 6 mismatches
    sweep(3, cyc);
    check("sat_done_cyc", 32'(cyc), 32'd17);
    check("sat_err", 32'(sat_err), 32'd3);
    check("sat_first", 32'(sat_first), 32'd2);
    check("sat_pass", 32'(sat_pass), 32'd0);

    // Reset mid-sweep while stim=1 in SETTLE
    nand_golden = 4'b0111;
    nand_use_and = 1'b1;
    nand_start = 1'b1;
    tick();
    nand_start = 1'b0;
    cyc = 1;
    while (nand_stim != 2'd1 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("mid_stim_cyc", 32'(cyc), 32'd3);
    check("mid_err_pre", 32'(nand_err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_stim", 32'(nand_stim), 32'd0);
    check("mid_rst_busy", 32'(nand_busy), 32'd0);
    check("mid_rst_done", 32'(nand_done), 32'd0);
    check("mid_rst_pass", 32'(nand_pass), 32'd0);
    check("mid_rst_err", 32'(nand_err), 32'd0);
    check("mid_rst_first", 32'(nand_first), 32'd0);
    nand_use_and = 1'b0;
    sweep(1, cyc);
    check("post_done_cyc", 32'(cyc), 32'd9);
    check("post_pass", 32'(nand_pass), 32'd1);
    check("post_err", 32'(nand_err), 32'd0);

    // start held high while busy must not disturb sequencing
    nand_start = 1'b1;
    tick();
    cyc = 1;
    while (!nand_done && cyc < 200) begin
      if (cyc == 8) nand_start = 1'b0;
      tick();
      cyc++;
      if (cyc == 3) check("busy_start_stim_c3", 32'(nand_stim), 32'd1);
      if (cyc == 5) check("busy_start_stim_c5", 32'(nand_stim), 32'd2);
      if (cyc == 7) check("busy_start_stim_c7", 32'(nand_stim), 32'd3);
    end
    nand_start = 1'b0;
    check("busy_start_done_cyc", 32'(cyc), 32'd9);
    check("busy_start_pass", 32'(nand_pass), 32'd1);

    // Restart from DONE
    nand_start = 1'b1;
    tick();
    nand_start = 1'b0;
    check("restart_done", 32'(nand_done), 32'd0);
    check("restart_busy", 32'(nand_busy), 32'd1);
    check("restart_stim", 32'(nand_stim), 32'd0);
    check("restart_pass", 32'(nand_pass), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
